// File: rtl/filter_phase_deadlock_reporter_if.sv
// AXI-Stream style report channel carrying {timestamp, info snapshot} words
// from the deadlock reporter to its downstream consumer.
interface filter_phase_deadlock_reporter_if #(
    parameter int DATA_W = 36
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/filter_phase_deadlock_reporter.sv
// Qualifies a deadlock once block persists THRESHOLD cycles, snapshots the per-channel
// info with a timestamp and emits one report word per continuous blocked episode.
module filter_phase_deadlock_reporter #(
    parameter int NUM_CHAN  = 2,
    parameter int THRESHOLD = 16,
    parameter int TS_W      = 32,
    parameter int CNT_W     = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      block,
    input  logic [2*NUM_CHAN-1:0]     axis_block_info,
    input  logic                      clear,
    filter_phase_deadlock_reporter_if.master m_report,
    output logic [NUM_CHAN-1:0]       blocked_mask,
    output logic                      deadlock_seen,
    output logic [CNT_W-1:0]          event_count
);

    localparam int                DATA_W   = TS_W + 2 * NUM_CHAN;
    localparam int                RUN_W    = 16;
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(THRESHOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        REPORT,
        HOLD
    } state_e;

    state_e               state_q;
    logic [RUN_W-1:0]     run_q;
    logic [TS_W-1:0]      ts_q;
    logic                 tvalid_q;
    logic [DATA_W-1:0]    tdata_q;
    logic [NUM_CHAN-1:0]  mask_q;
    logic [NUM_CHAN-1:0]  mask_d;
    logic                 seen_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 fire;

    always_comb begin
        mask_d = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            mask_d[i] = |axis_block_info[2*i +: 2];
        end
    end

    // A fire that coincides with clear restarts the count at one rather than zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = CNT_W'(1);
        end else if (count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign fire = block && (((state_q == IDLE) && (THRESHOLD == 1)) ||
                            ((state_q == ARMING) && (run_q == RUN_LAST)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            run_q    <= '0;
            ts_q     <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            mask_q   <= '0;
            seen_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (clear) begin
                seen_q  <= 1'b0;
                count_q <= '0;
            end
            if (fire) begin
                tdata_q  <= {ts_q, axis_block_info};
                mask_q   <= mask_d;
                seen_q   <= 1'b1;
                count_q  <= count_d;
                tvalid_q <= 1'b1;
                state_q  <= REPORT;
            end else begin
                // REPORT ignores block entirely so a pending word is never withdrawn.
                case (state_q)
                    IDLE: begin
                        if (block) begin
                            run_q   <= RUN_W'(1);
                            state_q <= ARMING;
                        end
                    end
                    ARMING: begin
                        if (!block) begin
                            run_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            run_q <= run_q + RUN_W'(1);
                        end
                    end
                    REPORT: begin
                        if (m_report.tready) begin
                            tvalid_q <= 1'b0;
                            state_q  <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (!block) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign m_report.tvalid = tvalid_q;
    assign m_report.tdata  = tdata_q;
    assign blocked_mask    = mask_q;
    assign deadlock_seen   = seen_q;
    assign event_count     = count_q;

endmodule
